// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cpu/dbg single-port memory arbiter.
// Optional build macro used elsewhere: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational owner select between the cpu and dbg requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise dbg wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_served,
`endif
    output logic any_req,
    output logic owner
);

    always_comb begin
        any_req = cpu_req | dbg_req;
        owner   = dbg_req ? REQ_DBG : REQ_CPU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (cpu_req && dbg_req) begin
            owner = ~last_served;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises cpu and dbg accesses onto one single-port synchronous memory.
// Build option MEM_ARB_ROUND_ROBIN_EN switches tie-breaking from fixed dbg priority to alternation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              owner_reg, owner_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;
    logic              capture;
    logic              pick_any;
    logic              pick_owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_served_reg, last_served_next;
`endif

    arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_served (last_served_reg),
`endif
        .any_req     (pick_any),
        .owner       (pick_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            owner_reg       <= REQ_CPU;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            cpu_rdata_reg   <= '0;
            dbg_rdata_reg   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served_reg <= REQ_CPU;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            owner_reg       <= owner_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            cpu_rdata_reg   <= cpu_rdata_next;
            dbg_rdata_reg   <= dbg_rdata_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served_reg <= last_served_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        owner_next       = owner_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        cpu_rdata_next   = cpu_rdata_reg;
        dbg_rdata_next   = dbg_rdata_reg;
        capture          = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_served_next = last_served_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_next = pick_owner;
                    if (pick_owner == REQ_DBG) begin
                        mem_we_next    = dbg_we;
                        mem_addr_next  = dbg_addr;
                        mem_wdata_next = dbg_wdata;
                    end else begin
                        mem_we_next    = cpu_we;
                        mem_addr_next  = cpu_addr;
                        mem_wdata_next = cpu_wdata;
                    end
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_served_next = owner_reg;
`endif
                if (mem_we_reg) begin
                    state_next = ST_DONE;
                end else if (MEM_LAT == 1) begin
                    // Single-cycle memory: data is already valid at the end of the issue cycle.
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next   = CNT_W'(MEM_LAT - 1);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (capture) begin
            if (owner_reg == REQ_DBG) begin
                dbg_rdata_next = mem_rdata;
            end else begin
                cpu_rdata_next = mem_rdata;
            end
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign mem_en    = (state_reg == ST_ISSUE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_gnt   = mem_en && (owner_reg == REQ_CPU);
    assign dbg_gnt   = mem_en && (owner_reg == REQ_DBG);
    assign cpu_done  = (state_reg == ST_DONE) && (owner_reg == REQ_CPU);
    assign dbg_done  = (state_reg == ST_DONE) && (owner_reg == REQ_DBG);
    assign cpu_rdata = cpu_rdata_reg;
    assign dbg_rdata = dbg_rdata_reg;

endmodule
